rtttl_voice_arbiter: RTL and testbench
======================================

Name: rtttl_voice_arbiter

Overview:
Shares the single downstream tone generator (octave/note pair) between NUM_REQ melody sources, such as several rtttl sequencers or effect voices. Grants one requester at a time using round-robin order. Forwards the granted requester's octave/note with one-cycle registration. Inserts a silent guard gap between owners so that successive notes articulate, and can optionally force rotation after a maximum hold time.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
GAP_CYCLES, 2381, silent cycles inserted after every release (0 = no gap).
MAX_HOLD, 0, cycles after which an owner is forced off if another request is pending (0 = never force).
CNT_W, 24, width of the hold and gap counters. GAP_CYCLES and MAX_HOLD must fit in CNT_W.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester request, level-held while the requester wants the channel
req_octave  in  4*NUM_REQ  requester i at bits [4i+3:4i]
req_note  in  4*NUM_REQ  requester i at bits [4i+3:4i]
grant  out  NUM_REQ  one-hot owner, all zero when no owner (registered)
busy  out  1  state != IDLE (registered)
octave  out  4  forwarded octave, 0 = rest (registered)
note  out  4  forwarded note, 0 = rest (registered)

Behaviour:
- Reset: applied on clk edge with rstn=0.
  - Reset values: grant=0, busy=0, octave=0, note=0, state=IDLE, hold_cnt=0, gap_cnt=0, rr_last=NUM_REQ-1.
  - A reset asserted mid-grant or mid-gap aborts it at the next edge, with no residual output.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - Outputs are rest (0/0) and grant=0.
  - If any req bit is set at cycle t, the winner is the first set bit searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - At t+1: state=GRANT, grant=onehot(winner), rr_last=winner, hold_cnt=0, octave/note = the winner's inputs sampled at t.
  - With no request, stay in IDLE.
- GRANT with owner g:
  - Each cycle, octave/note <= req_octave[g]/req_note[g]. This gives one-cycle latency from the requester's inputs to the outputs.
  - hold_cnt increments each cycle and saturates at all-ones.
  - Release condition A: req[g]=0.
  - Release condition B: MAX_HOLD!=0, hold_cnt>=MAX_HOLD-1, and any other req bit set.
  - On release: grant=0 and octave/note=0 at the next edge.
    - If GAP_CYCLES>0, state=GUARD with gap_cnt=0.
    - Otherwise state=IDLE.
  - A and B true in the same cycle are treated as a single release.
  - req bits of non-owners are ignored except for evaluating B.
- GUARD:
  - Outputs are rest, grant=0, busy=1.
  - gap_cnt increments. When gap_cnt==GAP_CYCLES-1, the next state is IDLE.
  - Arbitration occurs in the IDLE cycle that follows, so re-grant latency after release is GAP_CYCLES+2 cycles.
- Fairness:
  - Because rr_last is updated on every grant, a requester that held the channel is searched last.
  - A forced-off owner that keeps req asserted re-enters arbitration normally.
- Invariants: grant is never multi-hot. octave/note are 0 whenever grant=0.

Optional Feature:
Macro RTTTL_ARB_PREEMPT_EN.
- Defined: requester 0 is a priority voice (e.g. an alarm).
  - In IDLE, req[0]=1 wins regardless of rr_last.
  - In GRANT with g!=0, req[0]=1 switches the owner directly to 0 at the next edge: no GUARD, hold_cnt=0, octave/note from requester 0, and rr_last is left unchanged, so rotation resumes after g.
  - Requester 0 is exempt from MAX_HOLD forcing.
- Undefined: requester 0 is an ordinary round-robin participant.

Test Plan:
- Reset, then req=0001 with octave/note 5/6 at cycle t -> grant=0001 and octave=5, note=6 at t+1; busy=1.
- Owner 0 drops req at cycle t, with GAP_CYCLES=4 -> grant=0 and outputs 0/0 at t+1; GUARD lasts 4 cycles; IDLE follows; a pending req[2] is granted at t+6.
- req=1111 held continuously, MAX_HOLD=10, GAP_CYCLES=0 -> grant order 0001, 0010, 0100, 1000, 0001; each owner holds 10 cycles.
- Owner changes octave/note from 4/12 to 5/4 mid-grant at cycle t -> outputs show 5/4 at t+1, with no gap.
- rstn=0 during GUARD or GRANT -> all outputs 0 at the next edge; after release, req=0100 with rr_last=3 is granted requester 2 at 1-cycle latency.
- With RTTTL_ARB_PREEMPT_EN: owner 2 granted, req[0] rises at t -> grant=0001 at t+1 with no rest cycle; after req[0] drops, requester 3 wins ahead of requester 1 when both request.

Source files
------------

// File: rtl/rtttl_voice_arbiter.sv
// rtttl_voice_arbiter: shares one downstream tone generator (octave/note)
// between NUM_REQ melody sources. Owners are picked round-robin, the owner's
// octave/note is forwarded through one register stage, and a silent guard gap
// follows every release so that consecutive notes articulate. An optional
// maximum hold time forces rotation when another source is waiting.
//
// Optional feature: define RTTTL_ARB_PREEMPT_EN to make requester 0 a priority
// voice. It wins arbitration outright, takes the channel from any other owner
// on the next edge with no guard gap, and is never forced off by MAX_HOLD.
// When the macro is left undefined, requester 0 is an ordinary participant.
module rtttl_voice_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2381,
    parameter int MAX_HOLD   = 0,
    parameter int CNT_W      = 24
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_octave,
    input  logic [4*NUM_REQ-1:0]   req_note,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [3:0]             octave,
    output logic [3:0]             note
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Hold limit and last guard count, precomputed at counter width.
    localparam logic             HOLD_EN     = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] MAX_HOLD_M1 = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [NUM_REQ-1:0]   grant_q,    grant_d;
    logic                 busy_q,     busy_d;
    logic [3:0]           octave_q,   octave_d;
    logic [3:0]           note_q,     note_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]     gap_cnt_q,  gap_cnt_d;
    logic [IDX_W-1:0]     rr_last_q,  rr_last_d;
    logic [IDX_W-1:0]     owner_q,    owner_d;

    logic [IDX_W-1:0]     win_s;
    logic                 others_s;
    logic                 rel_a_s;
    logic                 rel_b_s;
    logic                 preempt_s;

    // First set request bit searching last+1, last+2, ... modulo NUM_REQ.
    // Scanning from the farthest position toward the nearest lets the nearest
    // hit overwrite earlier ones.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        win = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (r[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // One-hot vector for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = {NUM_REQ{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    // Extract requester i's 4-bit field from a packed per-requester bus.
    function automatic logic [3:0] voice_field(input logic [4*NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]     i);
        return v[{i, 2'b00} +: 4];
    endfunction

    // Arbitration decisions derived from current state and requests.
    always_comb begin
        others_s = |(req & ~grant_q);
        rel_a_s  = ~req[owner_q];
`ifdef RTTTL_ARB_PREEMPT_EN
        win_s     = req[0] ? {IDX_W{1'b0}} : rr_pick(req, rr_last_q);
        preempt_s = (owner_q != {IDX_W{1'b0}}) && req[0];
        rel_b_s   = HOLD_EN && (hold_cnt_q >= MAX_HOLD_M1) && others_s &&
                    (owner_q != {IDX_W{1'b0}});
`else
        win_s     = rr_pick(req, rr_last_q);
        preempt_s = 1'b0;
        rel_b_s   = HOLD_EN && (hold_cnt_q >= MAX_HOLD_M1) && others_s;
`endif
    end

    // Next-state and next-output computation for the IDLE/GRANT/GUARD machine.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        octave_d   = octave_q;
        note_d     = note_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rr_last_d  = rr_last_q;
        owner_d    = owner_q;

        case (state_q)
            ST_IDLE: begin
                grant_d  = {NUM_REQ{1'b0}};
                octave_d = 4'd0;
                note_d   = 4'd0;
                if (|req) begin
                    state_d    = ST_GRANT;
                    grant_d    = onehot(win_s);
                    rr_last_d  = win_s;
                    owner_d    = win_s;
                    hold_cnt_d = {CNT_W{1'b0}};
                    octave_d   = voice_field(req_octave, win_s);
                    note_d     = voice_field(req_note, win_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (preempt_s) begin
                    // Priority voice takes over directly; rotation resumes after
                    // the displaced owner because rr_last is left alone.
                    state_d    = ST_GRANT;
                    owner_d    = {IDX_W{1'b0}};
                    grant_d    = onehot({IDX_W{1'b0}});
                    hold_cnt_d = {CNT_W{1'b0}};
                    octave_d   = voice_field(req_octave, {IDX_W{1'b0}});
                    note_d     = voice_field(req_note, {IDX_W{1'b0}});
                end else if (rel_a_s || rel_b_s) begin
                    grant_d  = {NUM_REQ{1'b0}};
                    octave_d = 4'd0;
                    note_d   = 4'd0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GUARD;
                        gap_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    octave_d = voice_field(req_octave, owner_q);
                    note_d   = voice_field(req_note, owner_q);
                    if (hold_cnt_q != CNT_MAX) begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
            end

            ST_GUARD: begin
                grant_d   = {NUM_REQ{1'b0}};
                octave_d  = 4'd0;
                note_d    = 4'd0;
                gap_cnt_d = gap_cnt_q + CNT_ONE;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GUARD;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = {NUM_REQ{1'b0}};
                octave_d = 4'd0;
                note_d   = 4'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            grant_q    <= {NUM_REQ{1'b0}};
            busy_q     <= 1'b0;
            octave_q   <= 4'd0;
            note_q     <= 4'd0;
            hold_cnt_q <= {CNT_W{1'b0}};
            gap_cnt_q  <= {CNT_W{1'b0}};
            rr_last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q    <= {IDX_W{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            octave_q   <= octave_d;
            note_q     <= note_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
        end
    end

    assign grant  = grant_q;
    assign busy   = busy_q;
    assign octave = octave_q;
    assign note   = note_q;

endmodule

// File: tb/tb_rtttl_voice_arbiter.sv
// Self-checking bench for rtttl_voice_arbiter. Two instances share stimulus:
// dut_a has a 4-cycle guard gap and no hold limit, dut_b has no gap and a
// 10-cycle hold limit. Expected outputs {grant, busy, octave, note} are queued
// when stimulus is applied and compared after the following clock edge.
module tb_rtttl_voice_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [15:0] req_octave;
    logic [15:0] req_note;

    logic [3:0]  grant_a, grant_b;
    logic        busy_a, busy_b;
    logic [3:0]  octave_a, octave_b;
    logic [3:0]  note_a, note_b;

    logic [12:0] obs_a;
    logic [12:0] obs_b;

    typedef struct {
        logic [12:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   passed;

    assign obs_a = {grant_a, busy_a, octave_a, note_a};
    assign obs_b = {grant_b, busy_b, octave_b, note_b};

    rtttl_voice_arbiter #(
        .NUM_REQ(4), .GAP_CYCLES(4), .MAX_HOLD(0), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rstn(rstn), .req(req),
        .req_octave(req_octave), .req_note(req_note),
        .grant(grant_a), .busy(busy_a), .octave(octave_a), .note(note_a)
    );

    rtttl_voice_arbiter #(
        .NUM_REQ(4), .GAP_CYCLES(0), .MAX_HOLD(10), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rstn(rstn), .req(req),
        .req_octave(req_octave), .req_note(req_note),
        .grant(grant_b), .busy(busy_b), .octave(octave_b), .note(note_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_voice(input int i, input logic [3:0] o, input logic [3:0] n);
        req_octave[4*i +: 4] = o;
        req_note[4*i +: 4]   = n;
    endtask

    task automatic push_exp(input logic [12:0] v, input string t);
        exp_t e;
        e.val = v;
        e.tag = t;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            push_exp(13'd0, "reset_a");
            push_exp(13'd0, "reset_b");
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
            else passed++;
            e = sb_q.pop_front();
            total++;
            if (obs_b !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_b, e.val);
            else passed++;
        end
    endtask

    task automatic test_first_grant();
        exp_t e;
        rstn = 1'b1;
        set_voice(0, 4'd5, 4'd6);
        req = 4'b0001;
        push_exp({4'b0001, 1'b1, 4'd5, 4'd6}, "first_grant");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
    endtask

    task automatic test_data_follow();
        exp_t e;
        set_voice(0, 4'd4, 4'd12);
        req = 4'b0011;
        push_exp({4'b0001, 1'b1, 4'd4, 4'd12}, "follow_4_12");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        set_voice(0, 4'd5, 4'd4);
        push_exp({4'b0001, 1'b1, 4'd5, 4'd4}, "follow_5_4");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        set_voice(1, 4'd9, 4'd9);
        push_exp({4'b0001, 1'b1, 4'd5, 4'd4}, "follow_nonowner_ignored");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
    endtask

    task automatic test_guard();
        exp_t e;
        set_voice(2, 4'd7, 4'd3);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) push_exp({4'b0000, 1'b1, 4'd0, 4'd0}, "guard_rest");
        push_exp(13'd0, "guard_idle");
        push_exp({4'b0100, 1'b1, 4'd7, 4'd3}, "guard_regrant");
        while (sb_q.size() > 0) begin
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        // Reset while requester 2 owns the channel.
        rstn = 1'b0;
        push_exp(13'd0, "reset_mid_grant");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        rstn = 1'b1;
        push_exp({4'b0100, 1'b1, 4'd7, 4'd3}, "post_reset_grant2");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        req = 4'b0000;
        push_exp({4'b0000, 1'b1, 4'd0, 4'd0}, "enter_guard");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        // Reset while in the guard gap.
        rstn = 1'b0;
        push_exp(13'd0, "reset_mid_guard");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        rstn = 1'b1;
        set_voice(1, 4'd9, 4'd1);
        req = 4'b0010;
        push_exp({4'b0010, 1'b1, 4'd9, 4'd1}, "post_guard_reset_grant1");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
    endtask

    task automatic test_max_hold();
        exp_t e;
        rstn = 1'b0;
        req  = 4'b0000;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) set_voice(i, 4'(i + 1), 4'(i + 8));
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++)
                push_exp({4'(1 << (r % 4)), 1'b1, 4'((r % 4) + 1), 4'((r % 4) + 8)}, "rotate_hold");
            if (r < 4) push_exp(13'd0, "rotate_idle");
        end
        while (sb_q.size() > 0) begin
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_b !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_b, e.val);
            else passed++;
        end
    endtask

    task automatic test_hold_alone();
        exp_t e;
        rstn = 1'b0;
        req  = 4'b0000;
        tick();
        rstn = 1'b1;
        req  = 4'b0001;
        for (int c = 0; c < 14; c++) push_exp({4'b0001, 1'b1, 4'd1, 4'd8}, "hold_alone");
        while (sb_q.size() > 0) begin
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_b !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_b, e.val);
            else passed++;
        end
        req = 4'b0011;
        push_exp(13'd0, "forced_release");
        push_exp({4'b0010, 1'b1, 4'd2, 4'd9}, "forced_next_owner");
        while (sb_q.size() > 0) begin
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_b !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_b, e.val);
            else passed++;
        end
    endtask

`ifdef RTTTL_ARB_PREEMPT_EN
    task automatic test_preempt();
        exp_t e;
        rstn = 1'b0;
        req  = 4'b0000;
        tick();
        rstn = 1'b1;
        set_voice(0, 4'd8, 4'd1);
        set_voice(1, 4'd9, 4'd1);
        set_voice(2, 4'd7, 4'd3);
        set_voice(3, 4'd6, 4'd2);
        req = 4'b0100;
        push_exp({4'b0100, 1'b1, 4'd7, 4'd3}, "preempt_owner2");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        req = 4'b0101;
        push_exp({4'b0001, 1'b1, 4'd8, 4'd1}, "preempt_switch");
        tick();
        e = sb_q.pop_front();
        total++;
        if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
        else passed++;
        req = 4'b1010;
        for (int i = 0; i < 4; i++) push_exp({4'b0000, 1'b1, 4'd0, 4'd0}, "preempt_guard");
        push_exp(13'd0, "preempt_idle");
        push_exp({4'b1000, 1'b1, 4'd6, 4'd2}, "preempt_resume3");
        while (sb_q.size() > 0) begin
            tick();
            e = sb_q.pop_front();
            total++;
            if (obs_a !== e.val) $display("FAIL %s: got %h expected %h", e.tag, obs_a, e.val);
            else passed++;
        end
    endtask
`endif

    initial begin
        total      = 0;
        passed     = 0;
        rstn       = 1'b0;
        req        = 4'b0000;
        req_octave = 16'h0000;
        req_note   = 16'h0000;
        test_reset();
        test_first_grant();
        test_data_follow();
        test_guard();
        test_reset_mid();
`ifdef RTTTL_ARB_PREEMPT_EN
        test_preempt();
`else
        test_max_hold();
        test_hold_alone();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
